// File: rtl/alu_core_pkg.sv
// -----------------------------------------------------------------------------
// alu_core_pkg
// Shared types and constants for the mmio_alu_core slot:
//   op_t       operation codes carried in CTRL[2:0]
//   state_t    sequencing FSM states
//   REG_*      word offsets of the slot registers
//   ST_*       bit positions inside the STATUS register
//   sat_inc()  32-bit saturating increment used by the cycle counter
// -----------------------------------------------------------------------------
package alu_core_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_MUL  = 3'd2,
      OP_DIV  = 3'd3,
      OP_SHL  = 3'd4,
      OP_SHR  = 3'd5,
      OP_SRA  = 3'd6,
      OP_RSVD = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [4:0] REG_OPA    = 5'd0;
   localparam logic [4:0] REG_OPB    = 5'd1;
   localparam logic [4:0] REG_CTRL   = 5'd2;
   localparam logic [4:0] REG_STATUS = 5'd3;
   localparam logic [4:0] REG_RES_LO = 5'd4;
   localparam logic [4:0] REG_RES_HI = 5'd5;
   localparam logic [4:0] REG_CYCLES = 5'd6;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_DZ   = 2;
   localparam int ST_OVR  = 3;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// -----------------------------------------------------------------------------
// alu_seq_muldiv
// Unsigned W-cycle sequential multiplier / restoring divider on magnitudes.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        load operands and begin W iteration steps
//   is_div       1: divide a_mag by b_mag, 0: multiply a_mag by b_mag
//   a_mag,b_mag  operand magnitudes, sampled on start
//   prod_or_q    low product word (MUL) or quotient (DIV)
//   rem_hi       high product word (MUL) or remainder (DIV)
//   last_step    high during the final iteration step
// Both operations share one {hi, lo} shift pair: MUL shifts right while
// accumulating into hi, DIV shifts left while building quotient bits in lo.
// -----------------------------------------------------------------------------
module alu_seq_muldiv
   import alu_core_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         is_div,
   input  logic [W-1:0] a_mag,
   input  logic [W-1:0] b_mag,
   output logic [W-1:0] prod_or_q,
   output logic [W-1:0] rem_hi,
   output logic         last_step
);

   localparam int CW = $clog2(W);

   logic          active_q, active_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  hi_q, hi_d;
   logic [W-1:0]  lo_q, lo_d;
   logic [W-1:0]  m_q, m_d;
   logic          div_q, div_d;
   logic [W:0]    sum;
   logic [W:0]    shifted;

   assign last_step = active_q && (cnt_q == CW'(W - 1));
   assign prod_or_q = lo_q;
   assign rem_hi    = hi_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      active_d = active_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      m_d      = m_q;
      div_d    = div_q;
      sum      = {1'b0, hi_q} + {1'b0, m_q};
      shifted  = {hi_q, lo_q[W-1]};

      if (start) begin
         active_d = 1'b1;
         cnt_d    = '0;
         hi_d     = '0;
         lo_d     = a_mag;
         m_d      = b_mag;
         div_d    = is_div;
      end else if (active_q) begin
         cnt_d = cnt_q + CW'(1);
         if (last_step) active_d = 1'b0;
         if (div_q) begin
            // Restoring step: keep the trial subtraction only if it does not go negative.
            if (shifted >= {1'b0, m_q}) begin
               hi_d = shifted[W-1:0] - m_q;
               lo_d = {lo_q[W-2:0], 1'b1};
            end else begin
               hi_d = shifted[W-1:0];
               lo_d = {lo_q[W-2:0], 1'b0};
            end
         end else if (lo_q[0]) begin
            hi_d = sum[W:1];
            lo_d = {sum[0], lo_q[W-1:1]};
         end else begin
            hi_d = {1'b0, hi_q[W-1:1]};
            lo_d = {hi_q[0], lo_q[W-1:1]};
         end
      end
   end

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         active_q <= active_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: datapath registers carry no reset; start always loads them before use.
   always_ff @(posedge clk) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
      div_q <= div_d;
   end

endmodule

// File: rtl/mmio_alu_core.sv
// -----------------------------------------------------------------------------
// mmio_alu_core
// Width-parametrised arithmetic slot core for the FPro MMIO bus: add/sub,
// shifts, sequential multiply and restoring divide, with signed mode,
// busy/done/dz/ovr status and a per-operation busy-cycle counter.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   cs       slot select
//   read     read strobe (reads have no side effects)
//   write    write strobe
//   addr     word register offset
//   wr_data  write data
//   rd_data  read data, combinational from addr, W-bit fields zero-extended
// -----------------------------------------------------------------------------
module mmio_alu_core
   import alu_core_pkg::*;
#(
   parameter int W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        read,
   input  logic        write,
   input  logic [4:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data
);

   localparam int SW = $clog2(W);

   state_t       state_q, state_d;
   op_t          op_q, op_d;
   logic [W-1:0] opa_q, opa_d, opb_q, opb_d;
   logic [W-1:0] lat_a_q, lat_a_d, lat_b_q, lat_b_d;
   logic [W-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
   logic         neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic         dz_pend_q, dz_pend_d;
   logic         done_q, done_d, dz_q, dz_d, ovr_q, ovr_d;
   logic [31:0]  cyc_cnt_q, cyc_cnt_d, cycles_q, cycles_d;

   logic         wr_en, ctrl_wr, status_wr, busy;
   op_t          op_in;
   logic         sa_in, sb_in, div_zero_in, seq_start;
   logic [W-1:0] a_mag_in, b_mag_in;
   logic [W-1:0] seq_lo, seq_hi;
   logic         seq_last;
   logic [W:0]   sum_w, diff_w;
   logic [2*W-1:0] prod, prod_s;
   logic [SW-1:0]  amt;
   logic [W-1:0] fix_lo, fix_hi;
   logic         unused_sink;

   assign wr_en     = cs & write;
   assign ctrl_wr   = wr_en && (addr == REG_CTRL);
   assign status_wr = wr_en && (addr == REG_STATUS);
   assign busy      = (state_q != IDLE);

   // Sign handling only matters for MUL/DIV; other ops ignore the magnitudes.
   assign op_in       = op_t'(wr_data[2:0]);
   assign sa_in       = wr_data[3] & opa_q[W-1];
   assign sb_in       = wr_data[3] & opb_q[W-1];
   assign a_mag_in    = sa_in ? -opa_q : opa_q;
   assign b_mag_in    = sb_in ? -opb_q : opb_q;
   assign div_zero_in = (op_in == OP_DIV) && (opb_q == '0);
   assign seq_start   = ctrl_wr && !busy && (op_in inside {OP_MUL, OP_DIV}) && !div_zero_in;

   // read is part of the slot interface but reads are side-effect free.
   assign unused_sink = ^{read, wr_data};

   alu_seq_muldiv #(.W(W)) u_seq (
      .clk       (clk),
      .reset     (reset),
      .start     (seq_start),
      .is_div    (op_in == OP_DIV),
      .a_mag     (a_mag_in),
      .b_mag     (b_mag_in),
      .prod_or_q (seq_lo),
      .rem_hi    (seq_hi),
      .last_step (seq_last)
   );

   // Result formation for the FIX cycle.
   always_comb begin
      fix_lo = '0;
      fix_hi = '0;
      sum_w  = {1'b0, lat_a_q} + {1'b0, lat_b_q};
      diff_w = {1'b0, lat_a_q} - {1'b0, lat_b_q};
      prod   = {seq_hi, seq_lo};
      prod_s = neg_res_q ? -prod : prod;
      amt    = lat_b_q[SW-1:0];
      case (op_q)
         OP_ADD: begin
            fix_lo = sum_w[W-1:0];
            fix_hi = {{(W-1){1'b0}}, sum_w[W]};
         end
         OP_SUB: begin
            fix_lo = diff_w[W-1:0];
            fix_hi = {{(W-1){1'b0}}, diff_w[W]};
         end
         OP_MUL: {fix_hi, fix_lo} = prod_s;
         OP_DIV: begin
            if (dz_pend_q) begin
               fix_lo = '1;
               fix_hi = lat_a_q;
            end else begin
               fix_lo = neg_res_q ? -seq_lo : seq_lo;
               fix_hi = neg_rem_q ? -seq_hi : seq_hi;
            end
         end
         OP_SHL:  fix_lo = lat_a_q << amt;
         OP_SHR:  fix_lo = lat_a_q >> amt;
         OP_SRA:  fix_lo = W'($signed(lat_a_q) >>> amt);
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      lat_a_d   = lat_a_q;
      lat_b_d   = lat_b_q;
      res_lo_d  = res_lo_q;
      res_hi_d  = res_hi_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      dz_pend_d = dz_pend_q;
      done_d    = done_q;
      dz_d      = dz_q;
      ovr_d     = ovr_q;
      cyc_cnt_d = cyc_cnt_q;
      cycles_d  = cycles_q;

      if (wr_en && addr == REG_OPA) opa_d = wr_data[W-1:0];
      if (wr_en && addr == REG_OPB) opb_d = wr_data[W-1:0];
      if (status_wr) begin
         done_d = 1'b0;
         dz_d   = 1'b0;
         ovr_d  = 1'b0;
      end
      if (ctrl_wr && busy) ovr_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (ctrl_wr) begin
               op_d      = op_in;
               lat_a_d   = opa_q;
               lat_b_d   = opb_q;
               neg_res_d = sa_in ^ sb_in;
               neg_rem_d = sa_in;
               dz_pend_d = div_zero_in;
               done_d    = 1'b0;
               dz_d      = 1'b0;
               cyc_cnt_d = '0;
               state_d   = seq_start ? CALC : FIX;
            end
         end
         CALC: begin
            cyc_cnt_d = sat_inc(cyc_cnt_q);
            if (seq_last) state_d = FIX;
         end
         FIX: begin
            // Setting done/dz here overrides a same-cycle STATUS clear.
            res_lo_d = fix_lo;
            res_hi_d = fix_hi;
            done_d   = 1'b1;
            if (dz_pend_q) dz_d = 1'b1;
            cycles_d = sat_inc(cyc_cnt_q);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         op_q      <= OP_ADD;
         opa_q     <= '0;
         opb_q     <= '0;
         lat_a_q   <= '0;
         lat_b_q   <= '0;
         res_lo_q  <= '0;
         res_hi_q  <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_pend_q <= 1'b0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
         ovr_q     <= 1'b0;
         cyc_cnt_q <= '0;
         cycles_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         lat_a_q   <= lat_a_d;
         lat_b_q   <= lat_b_d;
         res_lo_q  <= res_lo_d;
         res_hi_q  <= res_hi_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         dz_pend_q <= dz_pend_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
         ovr_q     <= ovr_d;
         cyc_cnt_q <= cyc_cnt_d;
         cycles_q  <= cycles_d;
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         REG_OPA:    rd_data = 32'(opa_q);
         REG_OPB:    rd_data = 32'(opb_q);
         REG_STATUS: begin
            rd_data[ST_BUSY] = busy;
            rd_data[ST_DONE] = done_q;
            rd_data[ST_DZ]   = dz_q;
            rd_data[ST_OVR]  = ovr_q;
         end
         REG_RES_LO: rd_data = 32'(res_lo_q);
         REG_RES_HI: rd_data = 32'(res_hi_q);
         REG_CYCLES: rd_data = cycles_q;
         default:    rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_mmio_alu_core.sv
// -----------------------------------------------------------------------------
// tb_mmio_alu_core
// Drives a W=32 and a W=8 instance over a shared slot bus. Each issued
// operation pushes its expected response (from an arithmetic reference model)
// into exp_q; the driver collects what the DUT presents when busy drops into
// obs_q, and a separate monitor process pairs and compares them.
// -----------------------------------------------------------------------------
module tb_mmio_alu_core;

   localparam logic [4:0] A_OPA = 5'd0, A_OPB = 5'd1, A_CTRL = 5'd2, A_STATUS = 5'd3;
   localparam logic [4:0] A_RES_LO = 5'd4, A_RES_HI = 5'd5, A_CYCLES = 5'd6;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs32, cs8, read, write;
   logic [4:0]  addr;
   logic [31:0] wr_data, rd32, rd8;

   always #10 clk = ~clk;

   mmio_alu_core #(.W(32)) dut32 (
      .clk(clk), .reset(reset), .cs(cs32), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd32)
   );

   mmio_alu_core #(.W(8)) dut8 (
      .clk(clk), .reset(reset), .cs(cs8), .read(read), .write(write),
      .addr(addr), .wr_data(wr_data), .rd_data(rd8)
   );

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      logic        done;
      int unsigned cyc;
      int unsigned bcnt;
      string       tag;
   } resp_t;

   resp_t exp_q[$];
   resp_t obs_q[$];
   int    n_vec = 0;
   int    n_mis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Reference model: plain 64-bit integer arithmetic on the specified rules.
   function automatic resp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input int op, input bit sgn);
      resp_t r;
      longint unsigned mask, ua, ub, p;
      longint sa, sb, q, rm;
      logic [31:0] m32;
      int amt;
      mask = (64'd1 << w) - 64'd1;
      m32  = 32'(mask);
      ua   = {32'd0, a} & mask;
      ub   = {32'd0, b} & mask;
      sa   = ((ua >> (w - 1)) != 0) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
      sb   = ((ub >> (w - 1)) != 0) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
      amt  = int'(ub & longint'((1 << $clog2(w)) - 1));
      r.lo = 32'd0; r.hi = 32'd0; r.dz = 1'b0; r.done = 1'b1; r.cyc = 1; r.bcnt = 1; r.tag = "";
      case (op)
         0: begin
            p = ua + ub;
            r.lo = 32'(p) & m32;
            r.hi = 32'((p >> w) & 64'd1);
         end
         1: begin
            p = ua - ub;
            r.lo = 32'(p) & m32;
            r.hi = (ua < ub) ? 32'd1 : 32'd0;
         end
         2: begin
            if (sgn) p = sa * sb;
            else     p = ua * ub;
            r.lo  = 32'(p) & m32;
            r.hi  = 32'(p >> w) & m32;
            r.cyc = w + 1;
         end
         3: begin
            if (ub == 0) begin
               r.lo = m32;
               r.hi = 32'(ua);
               r.dz = 1'b1;
            end else begin
               if (sgn) begin
                  q  = sa / sb;
                  rm = sa % sb;
               end else begin
                  q  = longint'(ua / ub);
                  rm = longint'(ua % ub);
               end
               r.lo  = 32'(q) & m32;
               r.hi  = 32'(rm) & m32;
               r.cyc = w + 1;
            end
         end
         4: r.lo = 32'(ua << amt) & m32;
         5: r.lo = 32'(ua >> amt) & m32;
         6: begin
            rm   = sa >>> amt;
            r.lo = 32'(rm) & m32;
         end
         default: ;
      endcase
      r.bcnt = r.cyc;
      return r;
   endfunction

   task automatic bus_wr(input bit d8, input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cs32 = !d8; cs8 = d8; write = 1'b1; addr = a; wr_data = d;
      @(negedge clk);
      cs32 = 1'b0; cs8 = 1'b0; write = 1'b0;
   endtask

   task automatic bus_rd(input bit d8, input logic [4:0] a, output logic [31:0] v);
      addr = a; read = 1'b1;
      #1;
      v = d8 ? rd8 : rd32;
      read = 1'b0;
   endtask

   task automatic issue_op(input bit d8, input logic [31:0] a, input logic [31:0] b,
                           input int op, input bit sgn, input string tag);
      resp_t e;
      bus_wr(d8, A_OPA, a);
      bus_wr(d8, A_OPB, b);
      e = model(d8 ? 8 : 32, a, b, op, sgn);
      e.tag = tag;
      exp_q.push_back(e);
      bus_wr(d8, A_CTRL, {28'd0, sgn, 3'(op)});
   endtask

   // Counts busy cycles (skip = cycles already spent busy), then collects results.
   task automatic complete_op(input bit d8, input int skip);
      resp_t o;
      logic [31:0] v;
      int n = skip;
      int guard = 0;
      bit bsy = 1'b1;
      while (bsy && guard < 200) begin
         bus_rd(d8, A_STATUS, v);
         bsy = v[0];
         if (bsy) begin
            n++;
            @(negedge clk);
         end
         guard++;
      end
      if (bsy) begin
         n_vec++; n_mis++;
         $display("FAIL busy_timeout: still busy after %0d polls, required idle", guard);
      end
      bus_rd(d8, A_RES_LO, o.lo);
      bus_rd(d8, A_RES_HI, o.hi);
      bus_rd(d8, A_STATUS, v);
      o.dz = v[2]; o.done = v[1];
      bus_rd(d8, A_CYCLES, v);
      o.cyc  = v;
      o.bcnt = n;
      o.tag  = "";
      obs_q.push_back(o);
   endtask

   function automatic logic [31:0] rand_operand(input bit d8);
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return d8 ? 32'h80 : 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: pairs each presented response with the oldest expectation.
   initial begin
      resp_t e, o;
      forever begin
         @(posedge clk);
         while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
               n_vec++; n_mis++;
               $display("FAIL scoreboard: response with no expectation, lo=0x%08h", o.lo);
            end else begin
               e = exp_q.pop_front();
               check({e.tag, " res_lo"}, o.lo, e.lo);
               check({e.tag, " res_hi"}, o.hi, e.hi);
               check({e.tag, " dz"}, 32'(o.dz), 32'(e.dz));
               check({e.tag, " done"}, 32'(o.done), 32'(e.done));
               check({e.tag, " cycles"}, o.cyc, e.cyc);
               check({e.tag, " busy_len"}, o.bcnt, e.bcnt);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [31:0] acc;
      bit d8;
      int op;
      cs32 = 1'b0; cs8 = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         bus_rd(1'b0, 5'(i), v);
         check($sformatf("reset reg%0d", i), v, 32'd0);
      end

      issue_op(1'b0, 32'hFFFF_FFFF, 32'd2, 2, 1'b0, "mul ffffffff*2");
      complete_op(1'b0, 0);
      issue_op(1'b0, 32'hFFFF_FFF9, 32'd2, 3, 1'b1, "sdiv -7/2");
      complete_op(1'b0, 0);
      issue_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b1, "sdiv overflow");
      complete_op(1'b0, 0);
      issue_op(1'b0, 32'd123, 32'd0, 3, 1'b0, "div by zero");
      complete_op(1'b0, 0);
      bus_wr(1'b0, A_STATUS, 32'd0);
      bus_rd(1'b0, A_STATUS, v);
      check("status after clear", v, 32'd0);

      issue_op(1'b0, 32'h8000_00F0, 32'h24, 6, 1'b0, "sra by 4");
      complete_op(1'b0, 0);
      issue_op(1'b0, 32'h8000_00F0, 32'h24, 5, 1'b0, "shr by 4");
      complete_op(1'b0, 0);
      issue_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "add carry");
      complete_op(1'b0, 0);
      issue_op(1'b0, 32'd0, 32'd1, 1, 1'b0, "sub borrow");
      complete_op(1'b0, 0);
      issue_op(1'b0, 32'hFFFF_FFFD, 32'd5, 2, 1'b1, "smul -3*5");
      complete_op(1'b0, 0);
      issue_op(1'b0, 32'h1234_5678, 32'h9ABC, 7, 1'b0, "reserved op");
      complete_op(1'b0, 0);

      // CTRL and OPA writes while busy must not disturb the running MUL.
      issue_op(1'b0, 32'h0001_2345, 32'h0000_0FED, 2, 1'b0, "mul with busy writes");
      bus_wr(1'b0, A_OPA, 32'hDEAD_BEEF);
      repeat (2) @(negedge clk);
      bus_wr(1'b0, A_CTRL, 32'd0);
      complete_op(1'b0, 6);
      bus_rd(1'b0, A_STATUS, v);
      check("status ovr+done", v, 32'hA);
      bus_rd(1'b0, A_OPA, v);
      check("opa written while busy", v, 32'hDEAD_BEEF);
      bus_wr(1'b0, A_STATUS, 32'd0);
      bus_rd(1'b0, A_STATUS, v);
      check("status clear ovr", v, 32'd0);

      // Reset in the middle of a MUL aborts it.
      bus_wr(1'b0, A_OPA, 32'd7);
      bus_wr(1'b0, A_OPB, 32'd9);
      bus_wr(1'b0, A_CTRL, 32'd2);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus_rd(1'b0, 5'(i), v);
         check($sformatf("mid-op reset reg%0d", i), v, 32'd0);
      end
      acc = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         bus_rd(1'b0, A_STATUS, v);
         acc = acc | v;
      end
      check("no done after abort", acc, 32'd0);

      issue_op(1'b1, 32'hF0, 32'h0F, 2, 1'b0, "w8 mul f0*0f");
      complete_op(1'b1, 0);
      bus_rd(1'b1, A_RES_LO, v);
      check("w8 res_lo zero-extended", v, 32'h10);
      bus_wr(1'b1, A_OPA, 32'hFFFF_FF5A);
      bus_rd(1'b1, A_OPA, v);
      check("w8 opa width", v, 32'h5A);

      for (int i = 0; i < 150; i++) begin
         logic [31:0] a, b;
         bit sgn;
         d8  = (i % 4 == 3);
         op  = $urandom_range(0, 7);
         sgn = $urandom_range(0, 1);
         a   = rand_operand(d8);
         b   = rand_operand(d8);
         issue_op(d8, a, b, op, sgn,
                  $sformatf("rnd%0d w%0d op%0d s%0d a=%08h b=%08h", i, d8 ? 8 : 32, op, sgn, a, b));
         complete_op(d8, 0);
      end

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_vec++; n_mis++;
         $display("FAIL scoreboard: %0d expectations left unmatched, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
